// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with per-set LRU and flush.
// Misses fill a whole line word by word and forward the requested word.
module icache_2way #(
   parameter int INDEX_BITS  = 6,
   parameter int OFFSET_BITS = 2,
   parameter int ADDR_BITS   = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic [31:0] pc_from_if,
   output logic        inst_enable,
   output logic [31:0] inst_to_if,
   output logic        memc_enable,
   output logic [31:0] addr_to_memc,
   input  logic        memc_valid,
   input  logic [31:0] inst_from_memc
);
   localparam int SETS  = 1 << INDEX_BITS;
   localparam int WORDS = 1 << OFFSET_BITS;
   localparam int TAG_LO = 2 + OFFSET_BITS + INDEX_BITS;
   localparam int TAG_W = ADDR_BITS - TAG_LO;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   logic [31:0]       data_mem [2][SETS][WORDS];
   logic [TAG_W-1:0]  tags [2][SETS];
   logic [SETS-1:0]   valid [2];
   logic [SETS-1:0]   lru;
   logic [31:0]       line_buf [WORDS];

   state_t                 state, state_n;
   logic [OFFSET_BITS-1:0] cnt, cnt_n;
   logic [31:0]            fill_base;
   logic [INDEX_BITS-1:0]  fill_index;
   logic                   victim;
   logic                   discard;
   logic                   mem_en_n;
   logic [31:0]            addr_n;
   logic                   start, capture, last, install;

   logic [OFFSET_BITS-1:0] off;
   logic [INDEX_BITS-1:0]  idx;
   logic [TAG_W-1:0]       tag;
   logic                   hit0, hit1, hit, vic;
   logic [31:0]            base;

   assign off  = pc_from_if[2+OFFSET_BITS-1:2];
   assign idx  = pc_from_if[TAG_LO-1:2+OFFSET_BITS];
   assign tag  = pc_from_if[ADDR_BITS-1:TAG_LO];
   assign base = {pc_from_if[31:2+OFFSET_BITS], {(OFFSET_BITS+2){1'b0}}};

   assign hit0 = valid[0][idx] && (tags[0][idx] == tag);
   assign hit1 = valid[1][idx] && (tags[1][idx] == tag);
   assign hit  = hit0 || hit1;

   // Prefer an empty way; otherwise evict the one LRU points at.
   assign vic = !valid[0][idx] ? 1'b0 :
                !valid[1][idx] ? 1'b1 : lru[idx];

   always_comb begin
      inst_to_if = inst_from_memc;
      if (hit0)
         inst_to_if = data_mem[0][idx][off];
      else if (hit1)
         inst_to_if = data_mem[1][idx][off];
   end

   assign inst_enable = hit ||
                        (memc_valid && addr_to_memc == pc_from_if);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mem_en_n = memc_enable;
      addr_n   = addr_to_memc;
      start    = 1'b0;
      capture  = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!hit && !flush) begin
               start    = 1'b1;
               cnt_n    = '0;
               mem_en_n = 1'b1;
               addr_n   = base;
               state_n  = WAIT;
            end
         end
         REQ: begin
            mem_en_n = 1'b1;
            addr_n   = fill_base +
                       {{(30-OFFSET_BITS){1'b0}}, cnt, 2'b00};
            state_n  = WAIT;
         end
         WAIT: begin
            if (memc_valid) begin
               capture  = 1'b1;
               mem_en_n = 1'b0;
               if (&cnt) begin
                  last    = 1'b1;
                  state_n = IDLE;
               end else begin
                  cnt_n   = cnt + 1'b1;
                  state_n = REQ;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      install = last && !discard && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         memc_enable  <= 1'b0;
         addr_to_memc <= '0;
         valid[0]     <= '0;
         valid[1]     <= '0;
         lru          <= '0;
         discard      <= 1'b0;
         fill_base    <= '0;
         fill_index   <= '0;
         victim       <= 1'b0;
      end else if (rdy) begin
         state        <= state_n;
         cnt          <= cnt_n;
         memc_enable  <= mem_en_n;
         addr_to_memc <= addr_n;
         if (start) begin
            fill_base  <= base;
            fill_index <= idx;
            victim     <= vic;
            discard    <= 1'b0;
         end
         if (hit)
            lru[idx] <= hit0;
         if (install) begin
            valid[victim][fill_index] <= 1'b1;
            tags[victim][fill_index]  <= fill_base[ADDR_BITS-1:TAG_LO];
            lru[fill_index]           <= ~victim;
         end
         // Flush wins over any same-cycle install or LRU touch.
         if (flush) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
            if (state != IDLE)
               discard <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (capture)
            line_buf[cnt] <= inst_from_memc;
         if (install)
            for (int k = 0; k < WORDS; k++)
               data_mem[victim][fill_index][k] <=
                  (k == WORDS-1) ? inst_from_memc : line_buf[k];
      end
   end
endmodule
